// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator and the dot-product sequencer
// that drives it.
package mac_pkg;

    localparam int DW_DEF  = 16;
    localparam int AW_DEF  = 32;
    // Edges from a registered operand pair to the matching accumulator update.
    localparam int MAC_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mac.sv
// Single-stage signed multiply-accumulate; rst is a synchronous clear strobe.
// Its latency matches mac_pkg::MAC_LAT = 1.
module mac
    import mac_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] acc
);

    logic signed [2*DW-1:0] prod;
    logic        [AW-1:0]   acc_q;

    assign prod = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
    assign acc  = acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_q + AW'(prod);
        end
    end

endmodule

// File: rtl/mac_dot_fsm.sv
// Control for the dot-product sequencer: job state, pair counter and the
// drain counter that waits out the MAC latency.
module mac_dot_fsm
    import mac_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             in_ready,
    output logic             mac_clr,
    output logic             feed_hs,
    output logic             capture
);

    localparam int                DRAIN_W    = $clog2(MAC_LAT + 2);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT);

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [DRAIN_W-1:0] drain_q;
    logic               busy_q;
    logic               in_ready_q;
    logic               mac_clr_q;

    assign busy     = busy_q;
    assign in_ready = in_ready_q;
    assign mac_clr  = mac_clr_q;
    assign feed_hs  = in_ready_q && in_valid;
    // Final drain edge: the accumulator now holds the last pair's contribution.
    assign capture  = (state_q == ST_DRAIN) && (drain_q == DRAIN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            mac_clr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q     <= len;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        mac_clr_q <= 1'b1;
                        state_q   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    mac_clr_q <= 1'b0;
                    drain_q   <= '0;
                    if (len_q == '0) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (feed_hs) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cnt_q + LEN_W'(1) == len_q) begin
                            in_ready_q <= 1'b0;
                            state_q    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (capture) begin
                        state_q <= ST_DONE;
                    end else begin
                        drain_q <= drain_q + DRAIN_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams operand pairs into the MAC, inserting zeros
// on stalls, then returns the captured accumulator on a valid/ready port.
module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    output logic             mac_clr,
    output logic [DW-1:0]    mac_a,
    output logic [DW-1:0]    mac_b,
    input  logic [AW-1:0]    mac_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_data
);

    logic          feed_hs;
    logic          capture;
    logic [DW-1:0] mac_a_q, mac_a_d;
    logic [DW-1:0] mac_b_q, mac_b_d;
    logic [AW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    mac_dot_fsm #(
        .LEN_W(LEN_W)
    ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .in_ready (in_ready),
        .mac_clr  (mac_clr),
        .feed_hs  (feed_hs),
        .capture  (capture)
    );

    // The MAC has no enable, so every cycle without a handshake feeds 0*0.
    always_comb begin
        mac_a_d     = '0;
        mac_b_d     = '0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (feed_hs) begin
            mac_a_d = in_a;
            mac_b_d = in_b;
        end
        if (capture) begin
            out_data_d  = mac_acc;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq driving the mac model; inputs are driven and
// outputs sampled on the falling edge.
module tb_mac_dot_seq;

    localparam int DW    = 16;
    localparam int AW    = 32;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_a;
    logic [DW-1:0]    in_b;
    logic             mac_clr;
    logic [DW-1:0]    mac_a;
    logic [DW-1:0]    mac_b;
    logic [AW-1:0]    mac_acc;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_data;

    logic signed [DW-1:0] pa [8];
    logic signed [DW-1:0] pb [8];
    int                   total;
    int                   bad;
    int                   lat;
    logic signed [AW-1:0] res;

    mac_dot_seq #(
        .DW   (DW),
        .AW   (AW),
        .LEN_W(LEN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .mac_clr  (mac_clr),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_acc  (mac_acc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    mac #(
        .DW(DW),
        .AW(AW)
    ) u_mac (
        .clk(clk),
        .rst(mac_clr),
        .a  (mac_a),
        .b  (mac_b),
        .acc(mac_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " in_ready"}, in_ready, 0);
        checkOutput({tag, " mac_clr"}, mac_clr, 0);
        checkOutput({tag, " mac_a"}, mac_a, 0);
        checkOutput({tag, " mac_b"}, mac_b, 0);
        checkOutput({tag, " out_valid"}, out_valid, 0);
        checkOutput({tag, " out_data"}, out_data, 0);
    endtask

    // Called on a falling edge; returns on the falling edge where out_valid is first seen.
    task automatic applyStimulus(input int n, input int stallAfter, input int stallLen,
                                 output int latOut, output logic signed [AW-1:0] resOut);
        int            idx, gap, edges, clrCount;
        logic          hs, expectZero;
        logic [DW-1:0] expA, expB;
        idx = 0; gap = 0; edges = 0; clrCount = 0;
        hs = 1'b0; expectZero = 1'b0; expA = '0; expB = '0;
        latOut = -1; resOut = '0;
        start = 1'b1;
        len   = LEN_W'(n);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (edges < 300) begin
            if (mac_clr) clrCount++;
            if (edges == 0) begin
                checkOutput("mac_clr after start", mac_clr, 1);
                checkOutput("in_ready during clear", in_ready, 0);
            end
            if (edges == 1) checkOutput("in_ready after clear", in_ready, (n > 0));
            if (hs) begin
                checkOutput("mac_a on handshake", mac_a, expA);
                checkOutput("mac_b on handshake", mac_b, expB);
                if (idx == n) checkOutput("in_ready after last pair", in_ready, 0);
            end else if (expectZero && edges > 0) begin
                checkOutput("mac_a zero", mac_a, 0);
                checkOutput("mac_b zero", mac_b, 0);
            end
            if (out_valid) begin
                latOut = edges;
                resOut = $signed(out_data);
                break;
            end
            hs = 1'b0;
            expectZero = 1'b0;
            if (idx < n && idx == stallAfter && gap < stallLen) begin
                in_valid = 1'b0;
                if (in_ready) begin
                    gap++;
                    expectZero = 1'b1;
                end
            end else if (idx < n) begin
                in_valid = 1'b1;
                in_a = pa[idx];
                in_b = pb[idx];
                if (in_ready) begin
                    hs   = 1'b1;
                    expA = pa[idx];
                    expB = pb[idx];
                    idx++;
                end
            end else begin
                in_valid   = 1'b0;
                expectZero = 1'b1;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("out_valid seen", (latOut >= 0), 1);
        checkOutput("mac_clr pulse count", clrCount, 1);
    endtask

    // Holds out_ready low for a while with stray start pulses, then completes the handshake.
    task automatic releaseOutput(input int hold, input logic signed [AW-1:0] expData);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            start = (i % 2 == 0);
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold out_valid", out_valid, 1);
            checkOutput("hold out_data", $signed(out_data), expData);
            checkOutput("hold busy", busy, 1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("release out_valid", out_valid, 0);
        checkOutput("release busy", busy, 0);
        out_ready = 1'b0;
    endtask

    task automatic loadJobA();
        pa[0] = 2;   pb[0] = 3;
        pa[1] = 4;   pb[1] = -1;
        pa[2] = 100; pb[2] = 5;
        pa[3] = -10; pb[3] = 2;
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] four pairs, no stalls, output held off");
        loadJobA();
        applyStimulus(4, 99, 0, lat, res);
        checkOutput("A result", res, 482);
        checkOutput("A latency", lat, 7);
        releaseOutput(5, 482);

        $display("[TB] four pairs with a three-cycle stall");
        applyStimulus(4, 2, 3, lat, res);
        checkOutput("stall result", res, 482);
        checkOutput("stall latency", lat, 10);
        releaseOutput(0, 482);

        $display("[TB] zero-length job");
        applyStimulus(0, 99, 0, lat, res);
        checkOutput("len0 result", res, 0);
        checkOutput("len0 latency", lat, 3);
        releaseOutput(0, 0);

        $display("[TB] back-to-back jobs with out_ready high");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pa[i] = 1; pb[i] = 1;
        end
        applyStimulus(3, 99, 0, lat, res);
        checkOutput("b2b first result", res, 3);
        checkOutput("b2b first latency", lat, 6);
        start = 1'b1;
        @(negedge clk);
        checkOutput("b2b done one cycle", out_valid, 0);
        checkOutput("b2b busy falls", busy, 0);
        start = 1'b0;
        @(negedge clk);
        checkOutput("start in done ignored", busy, 0);
        for (int i = 0; i < 2; i++) begin
            pa[i] = -2; pb[i] = 5;
        end
        applyStimulus(2, 99, 0, lat, res);
        checkOutput("b2b second result", res, -20);
        checkOutput("b2b second latency", lat, 5);
        @(negedge clk);
        checkOutput("b2b second out_valid", out_valid, 0);
        checkOutput("b2b second busy", busy, 0);
        out_ready = 1'b0;

        $display("[TB] reset in the middle of a job");
        loadJobA();
        start = 1'b1;
        len = 8'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_a = pa[0];
        in_b = pb[0];
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        in_a = pa[1];
        in_b = pb[1];
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid-job mac_a", mac_a, 16'd4);
        checkOutput("mid-job busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 checkResetValues("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        pa[0] = 7; pb[0] = -3;
        applyStimulus(1, 99, 0, lat, res);
        checkOutput("after reset result", res, -21);
        checkOutput("after reset latency", lat, 4);
        releaseOutput(0, -21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
